vga_timing_checker: RTL and testbench

//   Receive-side monitor for the VGA sync interface: samples hsync/vsync on each pixel tick.

---
 rtl/vga_timing_checker.sv | 211 +++++++++++++++++++++
 tb/tb_vga_timing_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_checker.sv
// rtl/vga_timing_checker.sv - VGA hsync/vsync timing monitor with lock FSM
// Measures line length, hsync width and lines per frame; locks after LOCK_FRAMES good frames.
module vga_timing_checker #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC      = 96,
  parameter int SYNC_ACTIVE = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       timeout,
  output logic [7:0] err_count
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam int         TO_TICKS = 2 * H_TOTAL;
  localparam int         LW       = $clog2(TO_TICKS) + 1;
  localparam logic       ACT      = 1'(SYNC_ACTIVE);
  localparam logic [9:0] H_TOT_V  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT_V  = 10'(V_TOTAL);
  localparam logic [9:0] H_SYNC_V = 10'(H_SYNC);
  localparam logic [3:0] LOCK_V   = 4'(LOCK_FRAMES);

  logic [1:0]    r_state;
  logic [3:0]    r_good;
  logic          r_hs_act;
  logic          r_vs_act;
  logic          r_hs_seen;
  logic          r_bad;
  logic [9:0]    r_h_cnt;
  logic [9:0]    r_hs_w;
  logic [9:0]    r_lc;
  logic [9:0]    r_line_len;
  logic [9:0]    r_frame_lines;
  logic [LW-1:0] r_lost;
  logic          r_locked;
  logic          r_frame_ok;
  logic          r_frame_err;
  logic          r_timeout;
  logic [7:0]    r_err_count;

  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_hs_lead;
  logic          w_hs_trail;
  logic          w_vs_lead;
  logic [10:0]   w_h_inc;
  logic [9:0]    w_h_sat;
  logic [10:0]   w_hsw_inc;
  logic [9:0]    w_hsw_sat;
  logic [10:0]   w_lc_inc;
  logic [9:0]    w_lc_sat;
  logic [LW-1:0] w_lost_sat;
  logic          w_len_bad;
  logic          w_hsw_bad;
  logic          w_lines_bad;
  logic          w_frame_bad;
  logic          w_timeout;
  logic [3:0]    w_good_inc;
  logic [1:0]    w_state_nxt;
  logic [3:0]    w_good_nxt;
  logic          w_ok;
  logic          w_err;
  logic          w_err_inc;

  assign w_hs_act   = (hsync == ACT);
  assign w_vs_act   = (vsync == ACT);
  assign w_hs_lead  = pix_en & w_hs_act & ~r_hs_act;
  assign w_hs_trail = pix_en & ~w_hs_act & r_hs_act;
  assign w_vs_lead  = pix_en & w_vs_act & ~r_vs_act;

  assign w_h_inc    = {1'b0, r_h_cnt} + 11'd1;
  assign w_h_sat    = w_h_inc[10] ? 10'h3FF : w_h_inc[9:0];
  assign w_hsw_inc  = {1'b0, r_hs_w} + 11'd1;
  assign w_hsw_sat  = w_hsw_inc[10] ? 10'h3FF : w_hsw_inc[9:0];
  assign w_lc_inc   = {1'b0, r_lc} + 11'd1;
  assign w_lc_sat   = w_lc_inc[10] ? 10'h3FF : w_lc_inc[9:0];
  assign w_lost_sat = (&r_lost) ? r_lost : r_lost + LW'(1);

  // x_pos saturates at 1023, so hsync loss is timed by a wider private counter
  assign w_timeout  = pix_en & ~w_hs_lead & (r_state != ST_SEARCH) &
                      (r_lost == LW'(TO_TICKS - 1));

  assign w_len_bad   = w_hs_lead & r_hs_seen & (w_h_sat != H_TOT_V);
  assign w_hsw_bad   = w_hs_trail & (r_hs_w != H_SYNC_V);
  assign w_lines_bad = w_vs_lead & (r_lc != V_TOT_V);
  assign w_frame_bad = r_bad | w_len_bad | w_hsw_bad | w_lines_bad;
  assign w_good_inc  = r_good + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_err_inc   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_SEARCH;
      w_good_nxt  = 4'd0;
      w_err_inc   = 1'b1;
    end else if (w_vs_lead) begin
      case (r_state)
        ST_SEARCH: begin
          w_state_nxt = ST_MEASURE;
          w_good_nxt  = 4'd0;
        end
        ST_MEASURE: begin
          if (w_frame_bad) begin
            w_err      = 1'b1;
            w_err_inc  = 1'b1;
            w_good_nxt = 4'd0;
          end else begin
            w_ok       = 1'b1;
            w_good_nxt = w_good_inc;
            if (w_good_inc >= LOCK_V) w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_frame_bad) begin
            w_err       = 1'b1;
            w_err_inc   = 1'b1;
            w_good_nxt  = 4'd0;
            w_state_nxt = ST_MEASURE;
          end else begin
            w_ok = 1'b1;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_SEARCH;
      r_good        <= 4'd0;
      r_hs_act      <= 1'b0;
      r_vs_act      <= 1'b0;
      r_hs_seen     <= 1'b0;
      r_bad         <= 1'b0;
      r_h_cnt       <= 10'd0;
      r_hs_w        <= 10'd0;
      r_lc          <= 10'd0;
      r_line_len    <= 10'd0;
      r_frame_lines <= 10'd0;
      r_lost        <= '0;
      r_locked      <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout     <= 1'b0;
      r_err_count   <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      r_timeout   <= w_timeout;
      if (w_err_inc && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (pix_en) begin
        r_hs_act <= w_hs_act;
        r_vs_act <= w_vs_act;
        if (w_hs_lead) begin
          r_h_cnt    <= 10'd0;
          r_line_len <= w_h_sat;
          r_hs_w     <= 10'd1;
          r_lost     <= '0;
        end else begin
          r_h_cnt <= w_h_sat;
          r_lost  <= w_lost_sat;
          if (w_hs_act) r_hs_w <= w_hsw_sat;
        end
        if (w_timeout)      r_hs_seen <= 1'b0;
        else if (w_hs_lead) r_hs_seen <= 1'b1;
        // a coincident hsync edge is the first line of the new frame
        if (w_vs_lead) begin
          r_frame_lines <= r_lc;
          r_lc          <= w_hs_lead ? 10'd1 : 10'd0;
        end else if (w_hs_lead) begin
          r_lc <= w_lc_sat;
        end
        if (w_vs_lead)                   r_bad <= 1'b0;
        else if (w_len_bad | w_hsw_bad)  r_bad <= 1'b1;
      end
    end
  end

  assign x_pos       = r_h_cnt;
  assign y_pos       = r_lc;
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;
  assign locked      = r_locked;
  assign frame_ok    = r_frame_ok;
  assign frame_err   = r_frame_err;
  assign timeout     = r_timeout;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_vga_timing_checker.sv
// tb/tb_vga_timing_checker.sv - self-checking bench for vga_timing_checker
// Frame-level reference model; small raster keeps the run short.
module tb_vga_timing_checker;

  localparam int H  = 40;
  localparam int V  = 12;
  localparam int HS = 6;
  localparam int LF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] x_pos, y_pos, line_len, frame_lines;
  logic       locked, frame_ok, frame_err, timeout;
  logic [7:0] err_count;

  vga_timing_checker #(
    .H_TOTAL(H), .V_TOTAL(V), .H_SYNC(HS), .SYNC_ACTIVE(0), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .x_pos(x_pos), .y_pos(y_pos), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .frame_ok(frame_ok), .frame_err(frame_err), .timeout(timeout),
    .err_count(err_count)
  );

  bit clk_run = 1'b1;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // reference model: 0 search, 1 measure, 2 locked
  int m_state = 0;
  int m_good  = 0;
  int m_err   = 0;
  int since   = 0;
  bit hs_prev = 1'b0;
  bit vs_prev = 1'b0;
  bit cur_bad = 1'b0;
  bit g_full  = 1'b0;
  int g_last_len = H;
  bit gap_fixed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_err = 0; since = 0;
    hs_prev = 1'b0; vs_prev = 1'b0; cur_bad = 1'b0; g_full = 1'b0;
  endtask

  task automatic model_frame(input bit bad, output bit e_ok, output bit e_err);
    e_ok = 1'b0; e_err = 1'b0;
    if (m_state == 0) begin
      m_state = 1; m_good = 0;
    end else if (bad) begin
      e_err = 1'b1; m_err++; m_good = 0; m_state = 1;
    end else begin
      e_ok = 1'b1;
      if (m_state == 1) begin
        m_good++;
        if (m_good >= LF) m_state = 2;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, 32'(x_pos), 0);
    chk({tag, "_y"}, 32'(y_pos), 0);
    chk({tag, "_len"}, 32'(line_len), 0);
    chk({tag, "_lines"}, 32'(frame_lines), 0);
    chk({tag, "_pulses"}, 32'({locked, frame_ok, frame_err, timeout}), 0);
    chk({tag, "_errcnt"}, 32'(err_count), 0);
  endtask

  task automatic tick(input bit ha, input bit va);
    bit hl, vl, e_ok, e_err, e_to;
    int gap;
    @(negedge clk);
    pix_en = 1'b1;
    hsync  = ~ha;
    vsync  = ~va;
    @(posedge clk);
    #1;
    hl = ha && !hs_prev;
    vl = va && !vs_prev;
    hs_prev = ha;
    vs_prev = va;
    since = hl ? 0 : since + 1;
    e_ok = 1'b0; e_err = 1'b0; e_to = 1'b0;
    if (!hl && since == 2 * H && m_state != 0) begin
      e_to = 1'b1; m_state = 0; m_good = 0; m_err++;
    end else if (vl) begin
      model_frame(cur_bad, e_ok, e_err);
    end
    chk("frame_ok", 32'(frame_ok), int'(e_ok));
    chk("frame_err", 32'(frame_err), int'(e_err));
    chk("timeout", 32'(timeout), int'(e_to));
    chk("locked", 32'(locked), (m_state == 2) ? 1 : 0);
    chk("err_count", 32'(err_count), (m_err > 255) ? 255 : m_err);
    chk("x_pos", 32'(x_pos), (since > 1023) ? 1023 : since);
    if (vl) begin
      chk("y_pos_at_vs", 32'(y_pos), hl ? 1 : 0);
      if (g_full) begin
        chk("frame_lines", 32'(frame_lines), V);
        chk("line_len", 32'(line_len), g_last_len);
      end
      g_full = 1'b0;
    end
    gap = gap_fixed ? 3 : int'($urandom_range(0, 3));
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      pix_en = 1'b0;
      @(posedge clk);
      #1;
      chk("pulse_width", 32'({frame_ok, frame_err, timeout}), 0);
    end
  endtask

  // kind 0 good, 1 short line, 2 narrow hsync; vsync edge coincides with line 0 hsync edge
  task automatic send_frame(input int kind, input int bad_ln, input int nlines);
    int len, w;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (kind == 1 && ln == bad_ln) ? H - 1 : H;
      w   = (kind == 2 && ln == bad_ln) ? HS - 1 : HS;
      for (int t = 0; t < len; t++) begin
        tick(t < w, ln == 0);
        if (ln == 0 && t == 0) cur_bad = (kind != 0);
      end
      g_last_len = len;
    end
    g_full = (nlines == V);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_zero("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // nominal source, pix_en every 4th clock
    gap_fixed = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(0, 0, V);
    chk("locked_nominal", 32'(locked), 1);
    gap_fixed = 1'b0;

    // asynchronous reset mid-frame with the clock stopped
    send_frame(0, 0, 5);
    @(negedge clk);
    pix_en  = 1'b0;
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    #5 rst_n = 1'b1;
    model_reset();
    #1 chk("after_rst_locked", 32'(locked), 0);
    clk_run = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(0, 0, V);

    // one short line, then relock
    send_frame(1, int'($urandom_range(0, V - 1)), V);
    for (int f = 0; f < 3; f++) send_frame(0, 0, V);
    chk("relock_after_short", 32'(locked), 1);

    // one narrow hsync
    send_frame(2, int'($urandom_range(0, V - 1)), V);
    for (int f = 0; f < 3; f++) send_frame(0, 0, V);

    // hsync lost, then restart
    send_frame(0, 0, V);
    g_full = 1'b0;
    for (int i = 0; i < 2 * H + 10; i++) tick(1'b0, 1'b0);
    chk("locked_after_timeout", 32'(locked), 0);
    for (int f = 0; f < 4; f++) send_frame(0, 0, V);
    chk("relock_after_timeout", 32'(locked), 1);

    // rapid coincident vsync/hsync edges drive err_count into saturation
    for (int i = 0; i < 262; i++) begin
      tick(1'b1, 1'b1);
      cur_bad = 1'b1;
      tick(1'b0, 1'b0);
    end
    chk("err_saturated", 32'(err_count), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
